clock_display_formatter: RTL and testbench

Sequential formatter between the calendar decoder and the 7-segment scan driver. It snapshots the binary date/time fields and converts the fields needed for the selected view with one shared 14-bit double-dabble engine, one bit per cycle. It then assembles a DIGITS-wide BCD frame with separators, decimal points and digit blinking. It adds an auto-alternating time/date view, a weekday view and a valid/busy handshake.

---
 rtl/clock_display_formatter.sv | 155 +++++++++++++++
 tb/tb_clock_display_formatter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_formatter.sv
// clock_display_formatter: snapshots date/time fields, converts them through one serial
// double-dabble engine and assembles a blinkable BCD display frame.
module clock_display_formatter #(
    parameter int         DIGITS      = 8,
    parameter int         AUTO_PERIOD = 5,
    parameter logic [3:0] SEP_CODE    = 4'hA,
    parameter logic [3:0] BLANK_CODE  = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sec_tick,
    input  logic [1:0]            mode,
    input  logic [13:0]           year,
    input  logic [3:0]            month,
    input  logic [4:0]            day,
    input  logic [2:0]            weekday,
    input  logic [4:0]            hour,
    input  logic [5:0]            minute,
    input  logic [5:0]            second,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     dp,
    output logic                  frame_valid,
    output logic                  busy
);
    localparam int CW = AUTO_PERIOD > 1 ? $clog2(AUTO_PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, STORE, ASSEMBLE} state_t;
    typedef enum logic [1:0] {V_TIME, V_DATE, V_WDAY} view_t;

    state_t              state, state_n;
    view_t               view_l, view_eff;
    logic [1:0]          mode_q, fi;
    logic [CW-1:0]       auto_cnt, cnt_n, base_cnt;
    logic                auto_view, view_n, base_view;
    logic                blink_phase, blink_l, pending;
    logic                ev, start, ent, wrap, last_field;
    logic [3:0]          cnt;
    logic [29:0]         sh, sh_add;
    logic [13:0]         snap1, snap2, f0, f1, f2, year_c;
    logic [15:0]         r0;
    logic [7:0]          r1, r2;
    logic [31:0]         frame8;
    logic [4*DIGITS-1:0] digits_n;
    logic [DIGITS-1:0]   dp_n;

    always_comb begin
        ev         = sec_tick | (mode != mode_q);
        start      = (state == IDLE) && (ev | pending);
        ent        = start && mode == 2'd3 && mode_q != 2'd3;
        base_cnt   = ent ? '0 : auto_cnt;
        base_view  = ent ? 1'b0 : auto_view;
        wrap       = base_cnt == CW'(AUTO_PERIOD - 1);
        cnt_n      = sec_tick ? (wrap ? '0 : base_cnt + 1'b1) : base_cnt;
        view_n     = (sec_tick && wrap) ? ~base_view : base_view;
        view_eff   = mode == 2'd3 ? (view_n ? V_DATE : V_TIME) : view_t'(mode);
        year_c     = year > 14'd9999 ? 14'd9999 : year;
        f0         = view_eff == V_TIME ? {9'b0, hour} : view_eff == V_DATE ? year_c : {11'b0, weekday};
        f1         = view_eff == V_TIME ? {8'b0, minute} : {10'b0, month};
        f2         = view_eff == V_TIME ? {8'b0, second} : {9'b0, day};
        last_field = view_l == V_WDAY ? fi == 2'd0 : fi == 2'd2;
    end

    // add-3 correction on every BCD nibble before the shift
    always_comb begin
        sh_add = sh;
        for (int k = 0; k < 4; k++)
            sh_add[14+4*k +: 4] = sh[14+4*k +: 4] >= 4'd5 ? sh[14+4*k +: 4] + 4'd3 : sh[14+4*k +: 4];
    end

    always_comb begin
        frame8 = view_l == V_TIME ? {r0[7:0], SEP_CODE, r1, SEP_CODE, r2} :
                 view_l == V_DATE ? {r0, r1, r2} :
                 {{6{BLANK_CODE}}, SEP_CODE, r0[3:0]};
        digits_n = {DIGITS{BLANK_CODE}};
        for (int i = 0; i < 8; i++)
            digits_n[4*i +: 4] = (blink_l && blink_mask[i]) ? BLANK_CODE : frame8[4*i +: 4];
        dp_n    = '0;
        dp_n[4] = view_l == V_DATE;
        dp_n[2] = view_l == V_DATE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = start ? SHIFT : IDLE;
            SHIFT:   state_n = cnt == 4'd13 ? STORE : SHIFT;
            STORE:   state_n = last_field ? ASSEMBLE : SHIFT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= 2'd0;
            auto_cnt    <= '0;
            auto_view   <= 1'b0;
            blink_phase <= 1'b0;
            pending     <= 1'b0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            view_l      <= V_TIME;
            blink_l     <= 1'b0;
            fi          <= 2'd0;
            cnt         <= 4'd0;
            sh          <= '0;
            snap1       <= '0;
            snap2       <= '0;
            r0          <= '0;
            r1          <= '0;
            r2          <= '0;
            digits      <= {DIGITS{BLANK_CODE}};
            dp          <= '0;
        end else begin
            auto_cnt    <= cnt_n;
            auto_view   <= view_n;
            blink_phase <= blink_phase ^ sec_tick;
            frame_valid <= state == ASSEMBLE;
            pending     <= start ? 1'b0 : pending | ((state != IDLE) && ev);
            if (start) begin
                mode_q  <= mode;
                busy    <= 1'b1;
                view_l  <= view_eff;
                blink_l <= blink_phase;
                sh      <= {16'b0, f0};
                snap1   <= f1;
                snap2   <= f2;
                fi      <= 2'd0;
                cnt     <= 4'd0;
            end
            if (state == SHIFT) begin
                sh  <= {sh_add[28:0], 1'b0};
                cnt <= cnt + 4'd1;
            end
            if (state == STORE) begin
                if (fi == 2'd0) r0 <= sh[29:14];
                if (fi == 2'd1) r1 <= sh[21:14];
                if (fi == 2'd2) r2 <= sh[21:14];
                fi  <= fi + 2'd1;
                cnt <= 4'd0;
                sh  <= {16'b0, (fi == 2'd0 ? snap1 : snap2)};
            end
            // events seen during this frame keep busy high into the next refresh
            if (state == ASSEMBLE) begin
                digits <= digits_n;
                dp     <= dp_n;
                busy   <= pending | ev;
            end
        end
    end
endmodule

// File: tb/tb_clock_display_formatter.sv
// tb_clock_display_formatter: directed literal checks plus randomized stimulus
// compared every cycle against a transaction-level model of the formatter.
module tb_clock_display_formatter;
    localparam int AP = 2;

    logic        clk = 0, rst_n = 0, sec_tick = 0;
    logic [1:0]  mode = 0;
    logic [13:0] year = 0;
    logic [3:0]  month = 1;
    logic [4:0]  day = 1;
    logic [2:0]  weekday = 0;
    logic [4:0]  hour = 0;
    logic [5:0]  minute = 0, second = 0;
    logic [7:0]  blink_mask = 0;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic        frame_valid, busy;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    clock_display_formatter #(.DIGITS(8), .AUTO_PERIOD(AP)) dut (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .mode(mode), .year(year),
        .month(month), .day(day), .weekday(weekday), .hour(hour), .minute(minute),
        .second(second), .blink_mask(blink_mask), .digits(digits), .dp(dp),
        .frame_valid(frame_valid), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] frame_of(int v, int y, int mo, int d, int wd, int h,
                                             int mi, int s, bit ph, logic [7:0] m);
        int n[8];
        int yy;
        logic [31:0] f;
        if (v == 0) begin
            n[7] = h / 10;  n[6] = h % 10;  n[5] = 10;
            n[4] = mi / 10; n[3] = mi % 10; n[2] = 10;
            n[1] = s / 10;  n[0] = s % 10;
        end else if (v == 1) begin
            yy = y > 9999 ? 9999 : y;
            n[7] = yy / 1000; n[6] = (yy / 100) % 10; n[5] = (yy / 10) % 10; n[4] = yy % 10;
            n[3] = mo / 10;   n[2] = mo % 10;         n[1] = d / 10;         n[0] = d % 10;
        end else begin
            for (int i = 2; i < 8; i++) n[i] = 15;
            n[1] = 10;
            n[0] = wd;
        end
        for (int i = 0; i < 8; i++) begin
            if (ph && m[i]) n[i] = 15;
            f[4*i +: 4] = 4'(n[i]);
        end
        return f;
    endfunction

    // transaction-level model: a refresh is a snapshot plus a fixed latency countdown
    bit          m_act = 0, m_pend = 0, m_busy = 0, m_fv = 0, m_phase = 0, m_aview = 0, s_ph = 0;
    int          m_rem = 0, m_cnt = 0, m_view = 0;
    logic [1:0]  m_mq = 0;
    int          s_y, s_mo, s_d, s_wd, s_h, s_mi, s_s;
    logic [31:0] m_digits = 32'hFFFF_FFFF;
    logic [7:0]  m_dp = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_pend = 0; m_busy = 0; m_fv = 0; m_phase = 0; m_aview = 0;
            m_rem = 0; m_cnt = 0; m_view = 0; m_mq = 0; m_digits = 32'hFFFF_FFFF; m_dp = 0;
        end else begin
            bit evt, st;
            evt  = sec_tick || (mode != m_mq);
            st   = !m_act && (evt || m_pend);
            m_fv = 0;
            if (st && mode == 3 && m_mq != 3) begin
                m_cnt = 0;
                m_aview = 0;
            end
            if (sec_tick) begin
                if (m_cnt == AP - 1) begin
                    m_cnt = 0;
                    m_aview = !m_aview;
                end else m_cnt++;
            end
            if (st) begin
                m_view = mode == 3 ? int'(m_aview) : int'(mode);
                s_y = year; s_mo = month; s_d = day; s_wd = weekday;
                s_h = hour; s_mi = minute; s_s = second; s_ph = m_phase;
                m_act = 1; m_rem = m_view == 2 ? 16 : 46; m_busy = 1; m_pend = 0; m_mq = mode;
            end else if (m_act) begin
                if (evt) m_pend = 1;
                m_rem--;
                if (m_rem == 0) begin
                    m_digits = frame_of(m_view, s_y, s_mo, s_d, s_wd, s_h, s_mi, s_s, s_ph, blink_mask);
                    m_dp = m_view == 1 ? 8'b0001_0100 : 8'h00;
                    m_fv = 1; m_act = 0; m_busy = m_pend;
                end
            end
            m_phase = m_phase ^ sec_tick;
        end
    end

    always @(negedge clk) begin
        chk("digits", digits, m_digits);
        chk("dp", 32'(dp), 32'(m_dp));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("busy", 32'(busy), 32'(m_busy));
    end

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic trig(input bit tk, input logic [1:0] md, output int lat);
        sec_tick = tk;
        mode = md;
        @(negedge clk); #1;
        sec_tick = 0;
        lat = -1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk); #1;
            if (frame_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, nfv, c1, c2;
        logic [31:0] d1, d2;
        logic [7:0] a, b;
        int exp_time[6] = '{1, 0, 0, 1, 1, 0};
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1;
        chk("reset_digits", digits, 32'hFFFF_FFFF);
        chk("reset_dp", 32'(dp), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_fv", 32'(frame_valid), 0);
        idle(2);

        hour = 12; minute = 34; second = 56;
        trig(1, 0, lat);
        chk("time_latency", lat, 46);
        chk("time_digits", digits, 32'h12A3_4A56);
        chk("model_time", m_digits, 32'h12A3_4A56);
        chk("time_dp", 32'(dp), 0);
        chk("time_busy_end", 32'(busy), 0);
        idle(5);

        year = 2024; month = 8; day = 30;
        trig(1, 1, lat);
        chk("date_latency", lat, 46);
        chk("date_digits", digits, 32'h2024_0830);
        chk("date_dp", 32'(dp), 32'h14);
        idle(5);

        year = 12000;
        trig(1, 1, lat);
        chk("year_clamp", 32'(digits[31:16]), 32'h9999);
        idle(5);

        weekday = 3;
        trig(0, 2, lat);
        chk("wday_latency", lat, 16);
        chk("wday_digits", digits, 32'hFFFF_FFA3);
        chk("model_wday", m_digits, 32'hFFFF_FFA3);
        idle(5);

        year = 2024;
        trig(0, 3, lat);
        chk("auto_entry_view", 32'(digits[23:20]), 32'hA);
        idle(50);
        for (int i = 0; i < 6; i++) begin
            trig(1, 3, lat);
            chk($sformatf("auto_view_%0d", i), 32'(digits[23:20]), exp_time[i] ? 32'hA : 32'h2);
            idle(50);
        end

        trig(0, 0, lat);
        idle(5);
        nfv = 0; c1 = -1; c2 = -1; d1 = 0; d2 = 0;
        sec_tick = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            sec_tick = (c == 9 || c == 19);
            if (c == 46) begin hour = 1; minute = 2; second = 3; end
            if (frame_valid) begin
                nfv++;
                if (nfv == 1) begin c1 = c; d1 = digits; end
                else begin c2 = c; d2 = digits; end
            end
        end
        chk("coalesce_count", nfv, 2);
        chk("coalesce_first_at", c1, 46);
        chk("coalesce_first", d1, 32'h12A3_4A56);
        chk("coalesce_second_at", c2, 93);
        chk("coalesce_second", d2, 32'h01A0_2A03);
        hour = 12; minute = 34; second = 56;
        idle(5);

        blink_mask = 8'b0000_0011;
        trig(1, 0, lat);
        a = digits[7:0];
        idle(5);
        trig(1, 0, lat);
        b = digits[7:0];
        chk("blink_alternate", 32'(({a, b} == 16'h56FF) || ({a, b} == 16'hFF56)), 1);
        blink_mask = 0;
        idle(5);

        sec_tick = 1;
        @(negedge clk); #1;
        sec_tick = 0;
        idle(19);
        rst_n = 0;
        #1;
        chk("abort_digits", digits, 32'hFFFF_FFFF);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_fv", 32'(frame_valid), 0);
        idle(2);
        rst_n = 1;
        nfv = 0;
        repeat (80) begin
            @(negedge clk); #1;
            if (frame_valid) nfv++;
        end
        chk("abort_no_frame", nfv, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            sec_tick = $urandom_range(0, 39) == 0;
            rst_n = $urandom_range(0, 1499) != 0;
            if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                year = 14'($urandom_range(0, 16383));
                month = 4'($urandom_range(0, 15));
                day = 5'($urandom_range(0, 31));
                weekday = 3'($urandom_range(0, 7));
                hour = 5'($urandom_range(0, 31));
                minute = 6'($urandom_range(0, 63));
                second = 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 199) == 0) blink_mask = 8'($urandom_range(0, 255));
        end
        sec_tick = 0;
        rst_n = 1;
        idle(120);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
